// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the IF stage, its IF/ID register and the imem interface.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4 = 2'b00,
    PC_SRC_BR    = 2'b01,
    PC_SRC_JALR  = 2'b10,
    PC_SRC_RSVD  = 2'b11
  } pc_src_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// master = fetch stage, slave = synchronous-read memory.
interface if_fetch_stage_if #(
  parameter int AW = 10
) ();
  import if_fetch_stage_pkg::*;

  logic [AW-1:0]   o_imem_addr;
  logic            o_imem_en;
  logic [XLEN-1:0] i_imem_rdata;

  modport master (
    output o_imem_addr,
    output o_imem_en,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_addr,
    input  o_imem_en,
    output i_imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush > stall > advance priority.
// The hold register keeps the stalled instruction stable.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc_f,
  input  logic [XLEN-1:0] i_rdata,
  output if_id_t          o_if_id
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_hold;
  logic            r_valid;
  logic            r_hold_valid;
  logic            r_nop;
  logic            w_hold;

  assign w_hold = i_stall & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc         <= '0;
      r_pc_plus4   <= 32'd4;
      r_hold       <= '0;
      r_valid      <= 1'b0;
      r_hold_valid <= 1'b0;
      r_nop        <= 1'b1;
    end else if (i_clk_en) begin
      unique case (1'b1)
        i_flush: begin
          r_pc         <= i_pc_f;
          r_pc_plus4   <= i_pc_f + 32'd4;
          r_valid      <= 1'b0;
          r_hold_valid <= 1'b0;
          r_nop        <= 1'b1;
        end
        w_hold: begin
          if (!r_hold_valid) begin
            r_hold       <= i_rdata;
            r_hold_valid <= 1'b1;
          end
        end
        default: begin
          r_pc         <= i_pc_f;
          r_pc_plus4   <= i_pc_f + 32'd4;
          r_valid      <= 1'b1;
          r_hold_valid <= 1'b0;
          r_nop        <= 1'b0;
        end
      endcase
    end
  end

  // memory data pairs with r_pc one cycle after the fetch
  always_comb begin
    o_if_id.pc       = r_pc;
    o_if_id.pc_plus4 = r_pc_plus4;
    o_if_id.valid    = r_valid;
    o_if_id.instr    = i_rdata;
    if (r_nop)
      o_if_id.instr = NOP_INSTR;
    else if (r_hold_valid)
      o_if_id.instr = r_hold;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC select,
// imem port and IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int              IMEM_AW   = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  input  logic            i_pc_wr_en_h,
  input  logic            i_if_id_stall_h,
  input  logic            i_if_id_flush_h,
  input  logic [1:0]      i_pc_src_e,
  input  logic [XLEN-1:0] i_pc_target_e,
  input  logic [XLEN-1:0] i_alu_result_e,
  if_fetch_stage_if.master imem,
  output logic [XLEN-1:0] o_instr_d,
  output logic [XLEN-1:0] o_pc_d,
  output logic [XLEN-1:0] o_pc_plus4_d,
  output logic            o_valid_d,
  output logic            o_misaligned_f
);

  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] w_pc_plus4_f;
  logic [XLEN-1:0] w_pc_next;
  logic            w_redirect;
  logic            w_pc_ld;
  logic            r_misaligned;
  logic            w_unused;
  if_id_t          w_if_id;

  assign w_pc_plus4_f = r_pc_f + 32'd4;
  assign w_unused     = i_alu_result_e[0];

  always_comb begin
    w_pc_next  = w_pc_plus4_f;
    w_redirect = 1'b0;
    unique case (pc_src_e'(i_pc_src_e))
      PC_SRC_BR: begin
        w_pc_next  = i_pc_target_e;
        w_redirect = 1'b1;
      end
      PC_SRC_JALR: begin
        w_pc_next  = {i_alu_result_e[XLEN-1:1], 1'b0};
        w_redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // a redirect overrides a PC stall
  assign w_pc_ld = i_pc_wr_en_h | w_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_f       <= RESET_PC;
      r_misaligned <= 1'b0;
    end else if (i_clk_en) begin
      if (w_pc_ld)
        r_pc_f <= w_pc_next;
      r_misaligned <= w_redirect & w_pc_next[1];
    end
  end

  assign imem.o_imem_addr = r_pc_f[IMEM_AW+1:2];
  assign imem.o_imem_en   = i_clk_en & ~i_rst & ~i_if_id_stall_h;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clk_en (i_clk_en),
    .i_stall  (i_if_id_stall_h),
    .i_flush  (i_if_id_flush_h),
    .i_pc_f   (r_pc_f),
    .i_rdata  (imem.i_imem_rdata),
    .o_if_id  (w_if_id)
  );

  assign o_instr_d      = w_if_id.instr;
  assign o_pc_d         = w_if_id.pc;
  assign o_pc_plus4_d   = w_if_id.pc_plus4;
  assign o_valid_d      = w_if_id.valid;
  assign o_misaligned_f = r_misaligned;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage.
// Memory word n holds 32'h100+n; garbage when not enabled.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        pc_wr;
  logic        stall;
  logic        flush;
  logic [1:0]  src;
  logic [31:0] tgt;
  logic [31:0] alu;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic        mis;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  if_fetch_stage_if #(.AW(10)) imem ();

  if_fetch_stage dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_clk_en        (clk_en),
    .i_pc_wr_en_h    (pc_wr),
    .i_if_id_stall_h (stall),
    .i_if_id_flush_h (flush),
    .i_pc_src_e      (src),
    .i_pc_target_e   (tgt),
    .i_alu_result_e  (alu),
    .imem            (imem),
    .o_instr_d       (instr_d),
    .o_pc_d          (pc_d),
    .o_pc_plus4_d    (pc4_d),
    .o_valid_d       (valid_d),
    .o_misaligned_f  (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem.o_imem_en)
      imem.i_imem_rdata <= 32'h100 + {22'd0, imem.o_imem_addr};
    else
      imem.i_imem_rdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p,
                      input logic v);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    e.valid = v;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr_d, e.instr);
      chk({tag, "_pc"}, pc_d, e.pc);
      chk({tag, "_pc4"}, pc4_d, e.pc + 32'd4);
      chk({tag, "_valid"}, {31'd0, valid_d}, {31'd0, e.valid});
    end
  endtask

  task automatic idle();
    clk_en = 1'b1;
    pc_wr  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    src    = 2'b00;
    tgt    = '0;
    alu    = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    imem.i_imem_rdata = '0;
    idle();
    rst = 1'b1;
    #1;
    chk("en_in_rst", {31'd0, imem.o_imem_en}, 32'd0);
    push(32'h13, 32'h0, 1'b0);
    tick("rst");
    chk("rst_addr", {22'd0, imem.o_imem_addr}, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);

    rst = 1'b0;
    #1;
    chk("en_run", {31'd0, imem.o_imem_en}, 32'd1);
    for (int n = 0; n < 3; n++) begin
      push(32'h100 + n, 32'(4 * n), 1'b1);
      tick("seq");
      chk("seq_addr", {22'd0, imem.o_imem_addr}, 32'(n + 1));
    end

    stall = 1'b1;
    pc_wr = 1'b0;
    #1;
    chk("en_stall", {31'd0, imem.o_imem_en}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      push(32'h102, 32'h8, 1'b1);
      tick("stall");
    end
    idle();
    push(32'h103, 32'hC, 1'b1);
    tick("release");
    push(32'h104, 32'h10, 1'b1);
    tick("post_rel");

    src   = 2'b01;
    tgt   = 32'h40;
    flush = 1'b1;
    pc_wr = 1'b0;
    push(32'h13, 32'h14, 1'b0);
    tick("br_bubble");
    chk("br_addr", {22'd0, imem.o_imem_addr}, 32'h10);
    idle();
    push(32'h110, 32'h40, 1'b1);
    tick("br_tgt");

    src   = 2'b10;
    alu   = 32'h81;
    flush = 1'b1;
    push(32'h13, 32'h44, 1'b0);
    tick("jalr81_bub");
    chk("jalr81_mis", {31'd0, mis}, 32'd0);
    chk("jalr81_addr", {22'd0, imem.o_imem_addr}, 32'h20);
    idle();
    push(32'h120, 32'h80, 1'b1);
    tick("jalr81_tgt");

    src   = 2'b10;
    alu   = 32'h82;
    flush = 1'b1;
    push(32'h13, 32'h84, 1'b0);
    tick("jalr82_bub");
    chk("jalr82_mis", {31'd0, mis}, 32'd1);
    idle();
    push(32'h120, 32'h82, 1'b1);
    tick("jalr82_tgt");
    chk("jalr82_mis_end", {31'd0, mis}, 32'd0);
    push(32'h121, 32'h86, 1'b1);
    tick("jalr82_next");

    stall = 1'b1;
    flush = 1'b1;
    pc_wr = 1'b0;
    push(32'h13, 32'h8A, 1'b0);
    tick("stfl");
    idle();
    clk_en = 1'b0;
    #1;
    chk("en_cke0", {31'd0, imem.o_imem_en}, 32'd0);
    for (int n = 0; n < 2; n++) begin
      push(32'h13, 32'h8A, 1'b0);
      tick("cke0");
      chk("cke0_addr", {22'd0, imem.o_imem_addr}, 32'h22);
    end
    clk_en = 1'b1;
    push(32'h122, 32'h8A, 1'b1);
    tick("cke1");

    stall = 1'b1;
    pc_wr = 1'b0;
    push(32'h122, 32'h8A, 1'b1);
    tick("pre_rst_stall");
    rst = 1'b1;
    push(32'h13, 32'h0, 1'b0);
    tick("rst_stall");
    chk("rst_stall_addr", {22'd0, imem.o_imem_addr}, 32'd0);
    rst = 1'b0;
    idle();
    push(32'h100, 32'h0, 1'b1);
    tick("rst_resume");

    src   = 2'b10;
    alu   = 32'hFFFF_FFFD;
    flush = 1'b1;
    push(32'h13, 32'h4, 1'b0);
    tick("wrap_bub");
    chk("wrap_addr", {22'd0, imem.o_imem_addr}, 32'h3FF);
    idle();
    push(32'h4FF, 32'hFFFF_FFFC, 1'b1);
    tick("wrap_tgt");
    chk("wrap_pcf", {22'd0, imem.o_imem_addr}, 32'd0);
    push(32'h100, 32'h0, 1'b1);
    tick("wrap_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
